fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
// - IF stage of the pipelined ARM core; sits directly upstream of InstMemory.
// - Owns the PC register and drives PCF to InstMemory's PC input.
// - Captures the returned word (combinational, same cycle) into the IF/ID pipeline register for decode.
// - Handles hazard-unit stall/flush and execute-stage branch redirect.
// PARAMETERS
// - RESET_PC   32'h0000_0000  PCF value on reset
// - NOP_INSTR  32'hE1A00000   word (MOV R0,R0) loaded into InstrD on flush/reset
// PORTS
// - clk           in   1   rising-edge clock
// - reset         in   1   asynchronous, active-high reset
// - StallF        in   1   hold PCF
// - StallD        in   1   hold IF/ID register
// - FlushD        in   1   squash IF/ID register (bubble)
// - BranchTakenE  in   1   redirect fetch to BranchTargetE
// - BranchTargetE in   32  branch target byte address
// - InstrF        in   32  instruction word from InstMemory for current PCF
// - PCF           out  32  fetch address to InstMemory
// - InstrD        out  32  instruction to decode
// - PCD           out  32  address of InstrD
// - PCPlus8D      out  32  PCD+8 (architectural R15 read value)
// - ValidD        out  1   InstrD is a real, non-squashed instruction
// BEHAVIOUR
// - Reset (async, immediate, mid-cycle allowed): PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus8D=8, ValidD=0.
// - First edge after reset deassert: IF/ID captures InstrF @ RESET_PC, ValidD=1.
// - Next-PC priority per edge:
//   - BranchTakenE -> {BranchTargetE[31:2],2'b00} (overrides StallF)
//   - else StallF -> hold
//   - else PCF+4
// - PC arithmetic: 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0. PCF[1:0] always 00.
// - IF/ID update per edge, in priority order:
//   - FlushD -> InstrD=NOP_INSTR, ValidD=0, PCD/PCPlus8D hold. Flush beats StallD.
//   - else StallD -> all IF/ID outputs hold
//   - else InstrD=InstrF, PCD=PCF, PCPlus8D=PCF+8, ValidD=1
// - Latency: PCF->InstrD one cycle. Taken branch: target appears in InstrD one edge after redirect edge.
//   - Hazard unit asserts FlushD with BranchTakenE; PCF+4 slot wasted (1 bubble).
// - StallF=1, StallD=0: IF/ID re-captures the same InstrF each edge (duplicate); hazard unit must pair these. Block does not guard.
// - No internal FSM beyond PC/IF-ID regs; all outputs registered.
// CONFIGURATION
// - FETCH_PERF_EN defined: adds outputs FetchCount[31:0], BubbleCount[31:0].
//   - Async-reset to 0.
//   - FetchCount +1 on every edge where IF/ID loads a valid instr.
//   - BubbleCount +1 on every edge with FlushD=1.
//   - Both saturate at 32'hFFFFFFFF.
// - FETCH_PERF_EN undefined: ports and counters absent; core behaviour identical.
// TESTING
// - Memory loaded with MOV R0,#3 / CMP / BEQ / SUB / B loop / MOV R1,#42.
// 1. Reset held 2 cycles then released
//    -> PCF=0, ValidD=0, InstrD=E1A00000.
//    -> After 1 edge: InstrD=E3A00003, PCD=0, PCPlus8D=8, ValidD=1, PCF=4.
// 2. Free run 3 edges, no hazards
//    -> PCF=12; InstrD=0A000002; PCD=8.
// 3. BranchTakenE=1, BranchTargetE=32'h4 with FlushD=1 at PCF=20
//    -> Next edge: PCF=4, ValidD=0, InstrD=E1A00000.
//    -> Following edge: InstrD=E3500000, PCD=4.
// 4. StallF=StallD=1 for 3 cycles at PCF=8
//    -> PCF, InstrD, PCD unchanged. FlushD=1 with StallD=1 -> ValidD=0.
// 5. BranchTargetE=32'hFFFFFFFF taken
//    -> PCF=FFFFFFFC; next edge PCF=0 (wrap).
//    -> Separately: reset asserted mid-cycle -> outputs at reset values before next edge.
// 6. FETCH_PERF_EN build, scenario 1+2+3
//    -> FetchCount=5, BubbleCount=1.
//    -> Counter preloaded near max: saturates at FFFFFFFF.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// IF stage of the pipelined ARM core. Owns the PC register, drives PCF to the
// instruction memory, and registers the returned word into the IF/ID pipeline
// register. Handles hazard-unit stall/flush and the execute-stage branch
// redirect.
//
// Parameters
//   RESET_PC   : PCF value on reset
//   NOP_INSTR  : word (MOV R0,R0) loaded into InstrD on flush/reset
//
// Ports
//   clk           in   1   rising-edge clock
//   reset         in   1   asynchronous, active-high reset
//   StallF        in   1   hold PCF
//   StallD        in   1   hold IF/ID register
//   FlushD        in   1   squash IF/ID register (insert bubble)
//   BranchTakenE  in   1   redirect fetch to BranchTargetE
//   BranchTargetE in   32  branch target byte address
//   InstrF        in   32  instruction word for the current PCF (combinational)
//   PCF           out  32  fetch address
//   InstrD        out  32  instruction to decode
//   PCD           out  32  address of InstrD
//   PCPlus8D      out  32  PCD+8 (architectural R15 read value)
//   ValidD        out  1   InstrD is a real, non-squashed instruction
//   FetchCount    out  32  (FETCH_PERF_EN only) valid IF/ID loads, saturating
//   BubbleCount   out  32  (FETCH_PERF_EN only) flush edges, saturating
//
// Configuration
//   FETCH_PERF_EN : when defined, adds the FetchCount/BubbleCount counters.
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] BranchTargetE,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
`ifdef FETCH_PERF_EN
    output logic [31:0] FetchCount,
    output logic [31:0] BubbleCount,
`endif
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus8D,
    output logic        ValidD
);

    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pcd_reg, pcd_next;
    logic [31:0] pc_plus8_reg, pc_plus8_next;
    logic        valid_reg, valid_next;
    logic        load_valid;

    // Branch targets are word aligned; the low two bits are deliberately dropped.
    logic [1:0]  unused_target_lsbs;
    assign unused_target_lsbs = BranchTargetE[1:0];

    // Next-PC selection: a taken branch overrides StallF. Arithmetic wraps mod 2^32.
    always_comb begin
        pc_next = pc_reg + 32'd4;
        if (BranchTakenE) begin
            pc_next = {BranchTargetE[31:2], 2'b00};
        end else if (StallF) begin
            pc_next = pc_reg;
        end
    end

    // IF/ID update: flush beats stall; a flush keeps the PC fields so the
    // bubble still carries a sensible address.
    always_comb begin
        instr_next    = instr_reg;
        pcd_next      = pcd_reg;
        pc_plus8_next = pc_plus8_reg;
        valid_next    = valid_reg;
        load_valid    = 1'b0;
        if (FlushD) begin
            instr_next = NOP_INSTR;
            valid_next = 1'b0;
        end else if (!StallD) begin
            instr_next    = InstrF;
            pcd_next      = pc_reg;
            pc_plus8_next = pc_reg + 32'd8;
            valid_next    = 1'b1;
            load_valid    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg       <= RESET_PC;
            instr_reg    <= NOP_INSTR;
            pcd_reg      <= 32'd0;
            pc_plus8_reg <= 32'd8;
            valid_reg    <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            pcd_reg      <= pcd_next;
            pc_plus8_reg <= pc_plus8_next;
            valid_reg    <= valid_next;
        end
    end

    assign PCF      = pc_reg;
    assign InstrD   = instr_reg;
    assign PCD      = pcd_reg;
    assign PCPlus8D = pc_plus8_reg;
    assign ValidD   = valid_reg;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_reg, fetch_count_next;
    logic [31:0] bubble_count_reg, bubble_count_next;

    // Both counters saturate at all-ones rather than wrapping.
    always_comb begin
        fetch_count_next  = fetch_count_reg;
        bubble_count_next = bubble_count_reg;
        if (load_valid && (fetch_count_reg != 32'hFFFF_FFFF)) begin
            fetch_count_next = fetch_count_reg + 32'd1;
        end
        if (FlushD && (bubble_count_reg != 32'hFFFF_FFFF)) begin
            bubble_count_next = bubble_count_reg + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_reg  <= 32'd0;
            bubble_count_reg <= 32'd0;
        end else begin
            fetch_count_reg  <= fetch_count_next;
            bubble_count_reg <= bubble_count_next;
        end
    end

    assign FetchCount  = fetch_count_reg;
    assign BubbleCount = bubble_count_reg;
`else
    logic unused_load_valid;
    assign unused_load_valid = load_valid;
`endif

endmodule
